// File: rtl/aib_sideband_handshake_pkg.sv
// Shared types for the AIB sideband bring-up sequencer: FSM state and error code encodings.
package aib_sideband_handshake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_WAIT = 3'd1,
    ST_RDY_WAIT = 3'd2,
    ST_LINK_UP  = 3'd3,
    ST_ERROR    = 3'd4
  } hs_state_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_RST_TIMEOUT = 2'd1,
    ERR_RDY_TIMEOUT = 2'd2,
    ERR_LINK_DROP   = 2'd3
  } hs_err_e;

endpackage

// File: rtl/aib_sideband_handshake_if.sv
// Sideband bundle between the bring-up sequencer and its surroundings (CSRs, MAC, IO mapping).
interface aib_sideband_handshake_if;
  import aib_sideband_handshake_pkg::*;

  logic      c_chn_mst_mode;
  logic      c_hs_en;
  logic      i_mac_rdy;
  logic      i_fs_adapter_rstn;
  logic      i_fs_mac_rdy;
  logic      o_ns_adapter_rstn;
  logic      o_ns_mac_rdy;
  logic      o_link_up;
  hs_state_e o_state;
  hs_err_e   o_err_code;

  // master is the sequencer side; slave is the environment driving config and far-side pads
  modport master (
    input  c_chn_mst_mode, c_hs_en, i_mac_rdy, i_fs_adapter_rstn, i_fs_mac_rdy,
    output o_ns_adapter_rstn, o_ns_mac_rdy, o_link_up, o_state, o_err_code
  );

  modport slave (
    output c_chn_mst_mode, c_hs_en, i_mac_rdy, i_fs_adapter_rstn, i_fs_mac_rdy,
    input  o_ns_adapter_rstn, o_ns_mac_rdy, o_link_up, o_state, o_err_code
  );

endinterface

// File: rtl/aib_sideband_handshake_sb_filter.sv
// Far-side sideband input conditioner: synchronizer chain followed by a debounce filter.
module aib_sideband_handshake_sb_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_filt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_filt   = r_filt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
  end

  // Filtered value only flips after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_synced == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_filt <= w_synced;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/aib_sideband_handshake.sv
// Per-channel AIB link bring-up sequencer: filters far-side sideband, sequences reset release
// and MAC-ready, declares link-up and reports timeouts and link drops.
module aib_sideband_handshake
  import aib_sideband_handshake_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  aib_sideband_handshake_if.master        sb
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  hs_state_e     r_state;
  hs_err_e       r_err;
  logic          r_ns_rstn;
  logic          r_ns_mac_rdy;
  logic          r_link_up;
  logic [TW-1:0] r_tmo_cnt;
  logic          w_fs_rstn_filt;
  logic          w_fs_mac_rdy_filt;
  logic          w_tmo_hit;

  aib_sideband_handshake_sb_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_fs_rstn_filter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(sb.i_fs_adapter_rstn),
    .o_filt (w_fs_rstn_filt)
  );

  aib_sideband_handshake_sb_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_fs_mac_rdy_filter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(sb.i_fs_mac_rdy),
    .o_filt (w_fs_mac_rdy_filt)
  );

  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign sb.o_state           = r_state;
  assign sb.o_err_code        = r_err;
  assign sb.o_ns_adapter_rstn = r_ns_rstn;
  assign sb.o_ns_mac_rdy      = r_ns_mac_rdy;
  assign sb.o_link_up         = r_link_up;

  // Timeout counter defaults to zero and only advances while staying in a wait state
  always_ff @(posedge i_clk) begin
    if (i_rst || !sb.c_hs_en) begin
      r_state      <= ST_IDLE;
      r_err        <= ERR_NONE;
      r_ns_rstn    <= 1'b0;
      r_ns_mac_rdy <= 1'b0;
      r_link_up    <= 1'b0;
      r_tmo_cnt    <= '0;
    end else begin
      r_tmo_cnt <= '0;
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_RST_WAIT;
          r_ns_rstn <= sb.c_chn_mst_mode;
        end
        ST_RST_WAIT: begin
          if (w_fs_rstn_filt && r_ns_rstn) begin
            r_state <= ST_RDY_WAIT;
          end else if (w_tmo_hit) begin
            r_state   <= ST_ERROR;
            r_err     <= ERR_RST_TIMEOUT;
            r_ns_rstn <= 1'b0;
          end else begin
            if (sb.c_chn_mst_mode || w_fs_rstn_filt) r_ns_rstn <= 1'b1;
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        ST_RDY_WAIT: begin
          if (!w_fs_rstn_filt) begin
            r_state      <= ST_ERROR;
            r_err        <= ERR_LINK_DROP;
            r_ns_rstn    <= 1'b0;
            r_ns_mac_rdy <= 1'b0;
          end else if (w_fs_mac_rdy_filt && r_ns_mac_rdy) begin
            r_state      <= ST_LINK_UP;
            r_link_up    <= 1'b1;
            r_ns_mac_rdy <= sb.i_mac_rdy;
          end else if (w_tmo_hit) begin
            r_state      <= ST_ERROR;
            r_err        <= ERR_RDY_TIMEOUT;
            r_ns_rstn    <= 1'b0;
            r_ns_mac_rdy <= 1'b0;
          end else begin
            r_ns_mac_rdy <= sb.i_mac_rdy;
            r_tmo_cnt    <= r_tmo_cnt + TW'(1);
          end
        end
        ST_LINK_UP: begin
          if (!w_fs_rstn_filt || !w_fs_mac_rdy_filt || !sb.i_mac_rdy) begin
            r_state      <= ST_ERROR;
            r_err        <= ERR_LINK_DROP;
            r_ns_rstn    <= 1'b0;
            r_ns_mac_rdy <= 1'b0;
            r_link_up    <= 1'b0;
          end
        end
        ST_ERROR: begin
          r_state <= ST_ERROR;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_err        <= ERR_NONE;
          r_ns_rstn    <= 1'b0;
          r_ns_mac_rdy <= 1'b0;
          r_link_up    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aib_sideband_handshake.sv
// Directed bench for the AIB sideband bring-up sequencer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=64); far-side raw edges reach the filtered value 6 edges later.
module tb_aib_sideband_handshake;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  aib_sideband_handshake_if sbIf ();

  aib_sideband_handshake #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .sb   (sbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic hsEn, input logic mstMode, input logic macRdy,
                               input logic fsRstn, input logic fsMacRdy);
    sbIf.c_hs_en           = hsEn;
    sbIf.c_chn_mst_mode    = mstMode;
    sbIf.i_mac_rdy         = macRdy;
    sbIf.i_fs_adapter_rstn = fsRstn;
    sbIf.i_fs_mac_rdy      = fsMacRdy;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] st, input logic nsRstn,
                          input logic nsMacRdy, input logic linkUp, input logic [1:0] err);
    checkOutput({tag, "_state"}, 8'(sbIf.o_state), 8'(st));
    checkOutput({tag, "_nsRstn"}, 8'(sbIf.o_ns_adapter_rstn), 8'(nsRstn));
    checkOutput({tag, "_nsMacRdy"}, 8'(sbIf.o_ns_mac_rdy), 8'(nsMacRdy));
    checkOutput({tag, "_linkUp"}, 8'(sbIf.o_link_up), 8'(linkUp));
    checkOutput({tag, "_err"}, 8'(sbIf.o_err_code), 8'(err));
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkAll("reset", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;

    // Master bring-up: fs_rstn high at t0, fs_mac_rdy high at t20
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    checkAll("mst_t1", 3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
    tick(5);
    checkOutput("mst_t6_state", 8'(sbIf.o_state), 8'd1);
    tick(1);
    checkOutput("mst_t7_state", 8'(sbIf.o_state), 8'd2);
    tick(1);
    checkOutput("mst_t8_nsMacRdy", 8'(sbIf.o_ns_mac_rdy), 8'd1);
    tick(12);
    sbIf.i_fs_mac_rdy = 1'b1;
    tick(6);
    checkOutput("mst_t26_state", 8'(sbIf.o_state), 8'd2);
    tick(1);
    checkAll("mst_t27", 3'd3, 1'b1, 1'b1, 1'b1, 2'd0);

    // Far-side MAC ready drops for 10 cycles while linked
    sbIf.i_fs_mac_rdy = 1'b0;
    tick(6);
    checkOutput("drop_d6_state", 8'(sbIf.o_state), 8'd3);
    tick(1);
    checkAll("drop_d7", 3'd4, 1'b0, 1'b0, 1'b0, 2'd3);
    tick(3);
    sbIf.i_fs_mac_rdy = 1'b1;
    tick(10);
    checkAll("drop_hold", 3'd4, 1'b0, 1'b0, 1'b0, 2'd3);
    sbIf.c_hs_en = 1'b0;
    tick(1);
    checkAll("drop_idle", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Handshake disabled in the middle of RDY_WAIT
    sbIf.i_fs_mac_rdy = 1'b0;
    tick(8);
    sbIf.c_hs_en = 1'b1;
    tick(2);
    checkOutput("hsoff_rdywait", 8'(sbIf.o_state), 8'd2);
    tick(2);
    checkOutput("hsoff_nsMacRdy", 8'(sbIf.o_ns_mac_rdy), 8'd1);
    sbIf.c_hs_en = 1'b0;
    tick(1);
    checkAll("hsoff_idle", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Reset while linked; filters must restart from zero afterwards
    sbIf.i_fs_mac_rdy = 1'b1;
    tick(8);
    sbIf.c_hs_en = 1'b1;
    tick(4);
    checkOutput("rst_linkup", 8'(sbIf.o_link_up), 8'd1);
    rst = 1'b1;
    tick(1);
    checkAll("rst_mid", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    tick(6);
    checkOutput("rst_filt_x6", 8'(sbIf.o_state), 8'd1);
    tick(1);
    checkOutput("rst_filt_x7", 8'(sbIf.o_state), 8'd2);

    // Slave: fs_rstn held low 30 cycles, then released
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(8);
    sbIf.c_hs_en = 1'b1;
    tick(1);
    checkAll("slv_t1", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(29);
    checkOutput("slv_t30_nsRstn", 8'(sbIf.o_ns_adapter_rstn), 8'd0);
    sbIf.i_fs_adapter_rstn = 1'b1;
    tick(6);
    checkOutput("slv_r6_nsRstn", 8'(sbIf.o_ns_adapter_rstn), 8'd0);
    tick(1);
    checkOutput("slv_r7_nsRstn", 8'(sbIf.o_ns_adapter_rstn), 8'd1);
    checkOutput("slv_r7_state", 8'(sbIf.o_state), 8'd1);
    tick(1);
    checkOutput("slv_r8_state", 8'(sbIf.o_state), 8'd2);

    // Glitch rejection in RDY_WAIT: 3-cycle pulse ignored, 5-cycle pulse accepted
    sbIf.i_fs_mac_rdy = 1'b1;
    tick(3);
    sbIf.i_fs_mac_rdy = 1'b0;
    tick(6);
    checkOutput("glitch3_state", 8'(sbIf.o_state), 8'd2);
    sbIf.i_fs_mac_rdy = 1'b1;
    tick(5);
    sbIf.i_fs_mac_rdy = 1'b0;
    tick(1);
    checkOutput("pulse5_p6_state", 8'(sbIf.o_state), 8'd2);
    tick(1);
    checkAll("pulse5_p7", 3'd3, 1'b1, 1'b1, 1'b1, 2'd0);

    // Master reset-wait timeout at exactly 64 cycles
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(8);
    sbIf.c_hs_en = 1'b1;
    tick(1);
    tick(63);
    checkOutput("tmo_e63_state", 8'(sbIf.o_state), 8'd1);
    tick(1);
    checkAll("tmo_e64", 3'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    sbIf.c_hs_en = 1'b0;
    tick(1);
    checkOutput("tmo_idle_err", 8'(sbIf.o_err_code), 8'd0);

    // Filtered fs_rstn rises on cycle 63: exit wins over timeout
    sbIf.c_hs_en = 1'b1;
    tick(1);
    tick(57);
    sbIf.i_fs_adapter_rstn = 1'b1;
    tick(6);
    checkOutput("edge_e63_state", 8'(sbIf.o_state), 8'd1);
    tick(1);
    checkOutput("edge_e64_state", 8'(sbIf.o_state), 8'd2);
    checkOutput("edge_e64_err", 8'(sbIf.o_err_code), 8'd0);

    // Far-side MAC never ready: RDY_WAIT timeout
    tick(63);
    checkOutput("rdytmo_63_state", 8'(sbIf.o_state), 8'd2);
    tick(1);
    checkAll("rdytmo_64", 3'd4, 1'b0, 1'b0, 1'b0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
